// File: rtl/scan_text_arbiter.sv
// Single-writer arbiter for the VGA text RAM: clears the screen after reset, then
// round-robins between PS/2 scan bytes (rendered as "HH ") and CPU character writes.
module scan_text_arbiter #(
    parameter int COLS   = 80,
    parameter int ROWS   = 30,
    parameter int ADDR_W = 12
) (
    input  logic              clk_sys,
    input  logic              rst,
    input  logic              kb_valid,
    input  logic [7:0]        kb_data,
    output logic              kb_ready,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_gnt,
    output logic              vram_we,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [7:0]        vram_wdata,
    output logic [ADDR_W-1:0] cursor_pos,
    output logic              busy,
    output logic [2:0]        fsm_state
);

    localparam int TOTAL = COLS * ROWS;
    localparam logic [ADDR_W:0] TOTAL_X = (ADDR_W+1)'(TOTAL);

    localparam logic [2:0] ST_CLEAR  = 3'd0;
    localparam logic [2:0] ST_IDLE   = 3'd1;
    localparam logic [2:0] ST_KB_HI  = 3'd2;
    localparam logic [2:0] ST_KB_LO  = 3'd3;
    localparam logic [2:0] ST_KB_SP  = 3'd4;
    localparam logic [2:0] ST_CPU_WR = 3'd5;

    localparam logic [7:0] SPACE = 8'h20;

    logic [2:0]        state;
    logic [ADDR_W:0]   clr_cnt;
    logic [7:0]        kb_byte;
    logic              last_cpu;
    logic [ADDR_W-1:0] cursor;

    logic              idle;
    logic              grant_kb;
    logic              grant_cpu;
    logic              cpu_in_range;
    logic [ADDR_W:0]   cursor_plus3;
    logic [ADDR_W-1:0] cursor_next;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        // '0'..'9' then 'A'..'F': 0x37 + 10 lands on 0x41
        if (n < 4'd10) hex_char = 8'h30 + {4'h0, n};
        else           hex_char = 8'h37 + {4'h0, n};
    endfunction

    // Handshakes: a scan byte transfers on the cycle kb_valid & kb_ready are both high;
    // the source holds kb_valid/kb_data until then. cpu_req is held until the single-cycle
    // cpu_gnt, and cpu_addr/cpu_wdata are captured on that same cycle.
    always_comb begin
        idle         = (state == ST_IDLE);
        grant_kb     = !rst && idle && kb_valid && (!cpu_req || last_cpu);
        grant_cpu    = !rst && idle && cpu_req && (!kb_valid || !last_cpu);
        cpu_in_range = ({1'b0, cpu_addr} < TOTAL_X);
        cursor_plus3 = {1'b0, cursor} + (ADDR_W+1)'(3);
        if (cursor_plus3 >= TOTAL_X) cursor_next = '0;
        else                         cursor_next = cursor_plus3[ADDR_W-1:0];
    end

    assign kb_ready   = grant_kb;
    assign cpu_gnt    = grant_cpu;
    assign busy       = rst || !idle;
    assign cursor_pos = cursor;
    assign fsm_state  = state;

    // The vram_* registers are loaded on the edge entering each write state, so the
    // write is presented during that state's own cycle.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state      <= ST_CLEAR;
            clr_cnt    <= '0;
            kb_byte    <= '0;
            last_cpu   <= 1'b1;
            cursor     <= '0;
            vram_we    <= 1'b0;
            vram_addr  <= '0;
            vram_wdata <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (clr_cnt == TOTAL_X) begin
                        vram_we <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        vram_we    <= 1'b1;
                        vram_addr  <= clr_cnt[ADDR_W-1:0];
                        vram_wdata <= SPACE;
                        clr_cnt    <= clr_cnt + (ADDR_W+1)'(1);
                    end
                end
                ST_IDLE: begin
                    if (grant_kb) begin
                        vram_we    <= 1'b1;
                        vram_addr  <= cursor;
                        vram_wdata <= hex_char(kb_data[7:4]);
                        kb_byte    <= kb_data;
                        last_cpu   <= 1'b0;
                        state      <= ST_KB_HI;
                    end else if (grant_cpu) begin
                        last_cpu <= 1'b1;
                        state    <= ST_CPU_WR;
                        // Out-of-range cells are granted but silently dropped.
                        if (cpu_in_range) begin
                            vram_we    <= 1'b1;
                            vram_addr  <= cpu_addr;
                            vram_wdata <= cpu_wdata;
                        end else begin
                            vram_we <= 1'b0;
                        end
                    end else begin
                        vram_we <= 1'b0;
                    end
                end
                ST_KB_HI: begin
                    vram_addr  <= cursor + ADDR_W'(1);
                    vram_wdata <= hex_char(kb_byte[3:0]);
                    state      <= ST_KB_LO;
                end
                ST_KB_LO: begin
                    vram_addr  <= cursor + ADDR_W'(2);
                    vram_wdata <= SPACE;
                    state      <= ST_KB_SP;
                end
                ST_KB_SP: begin
                    vram_we <= 1'b0;
                    cursor  <= cursor_next;
                    state   <= ST_IDLE;
                end
                ST_CPU_WR: begin
                    vram_we <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    vram_we <= 1'b0;
                    clr_cnt <= '0;
                    state   <= ST_CLEAR;
                end
            endcase
        end
    end

endmodule
